// File: rtl/dk_sound_mixer.sv
// dk_sound_mixer: four-channel gain/sum/saturate audio mixer, 7-cycle strobe-to-out_valid latency.
// Define DK_MIX_LPF_EN to insert a one-pole low-pass filter (coefficient 2^-LPF_SHIFT) before the output.
module dk_sound_mixer #(
    parameter int         CLOCK_RATE  = 768000,
    parameter int         SAMPLE_RATE = 48000,
    parameter logic [7:0] GAIN_WALK   = 8'd128,
    parameter logic [7:0] GAIN_JUMP   = 8'd128,
    parameter logic [7:0] GAIN_STOMP  = 8'd128,
    parameter logic [7:0] GAIN_MUSIC  = 8'd128,
    parameter int         LPF_SHIFT   = 2
) (
    input  logic               clk,
    input  logic               I_RSTn,
    input  logic               audio_clk_en,
    input  logic signed [15:0] walk_in,
    input  logic signed [15:0] jump_in,
    input  logic signed [15:0] stomp_in,
    input  logic signed [15:0] music_in,
    output logic signed [15:0] out,
    output logic        [15:0] O_SOUND_DAT,
    output logic               out_valid,
    output logic               overrun
);
    if (CLOCK_RATE / SAMPLE_RATE < 8) begin : g_rate_chk
        $error("dk_sound_mixer: CLOCK_RATE/SAMPLE_RATE must be at least 8");
    end
    if (LPF_SHIFT < 1 || LPF_SHIFT > 8) begin : g_shift_chk
        $error("dk_sound_mixer: LPF_SHIFT must be in 1..8");
    end

    typedef enum logic [2:0] {IDLE, ACC, SAT, FILT, DONE} state_t;

    state_t             state_q;
    logic        [1:0]  idx_q;
    logic signed [15:0] ch_q [4];
    logic signed [25:0] acc_q;
    logic signed [15:0] x_q;
    logic        [7:0]  gain;
    logic signed [25:0] s_ext, g_ext, acc_d, shr;
    logic signed [15:0] sat_d, y_d;

    always_comb begin
        gain  = idx_q == 2'd0 ? GAIN_WALK : idx_q == 2'd1 ? GAIN_JUMP :
                idx_q == 2'd2 ? GAIN_STOMP : GAIN_MUSIC;
        s_ext = 26'(ch_q[idx_q]);
        g_ext = $signed(26'(gain));
        acc_d = acc_q + s_ext * g_ext;
        shr   = acc_q >>> 7;
        sat_d = shr > 26'sd32767 ? 16'sh7FFF : shr < -26'sd32768 ? 16'sh8000 : shr[15:0];
    end

`ifdef DK_MIX_LPF_EN
    logic signed [15:0] y_q;
    logic signed [16:0] diff;

    always_comb begin
        diff = 17'(x_q) - 17'(y_q);
        y_d  = y_q + 16'(diff >>> LPF_SHIFT);
    end

    always_ff @(posedge clk or negedge I_RSTn)
        if (!I_RSTn)
            y_q <= '0;
        else if (state_q == FILT)
            y_q <= y_d;
`else
    assign y_d = x_q;
`endif

    always_ff @(posedge clk or negedge I_RSTn)
        if (!I_RSTn) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            ch_q        <= '{default: '0};
            acc_q       <= '0;
            x_q         <= '0;
            out         <= '0;
            O_SOUND_DAT <= 16'h8000;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            // strobes that land while a sample is in flight are dropped, only flagged
            if (audio_clk_en && state_q != IDLE)
                overrun <= 1'b1;
            case (state_q)
                IDLE:
                    if (audio_clk_en) begin
                        ch_q    <= '{walk_in, jump_in, stomp_in, music_in};
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= ACC;
                    end
                ACC: begin
                    acc_q   <= acc_d;
                    idx_q   <= idx_q + 2'd1;
                    state_q <= idx_q == 2'd3 ? SAT : ACC;
                end
                SAT: begin
                    x_q     <= sat_d;
                    state_q <= FILT;
                end
                FILT: begin
                    out         <= y_d;
                    O_SOUND_DAT <= {~y_d[15], y_d[14:0]};
                    out_valid   <= 1'b1;
                    state_q     <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
endmodule

// File: doc/dk_sound_mixer.md
DK_SOUND_MIXER -- requirements
Module: dk_sound_mixer

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 768000, system clock rate in Hz.
REQ-002 SHALL have parameter SAMPLE_RATE, default 48000, output sample rate in Hz.
REQ-003 SHALL have parameters GAIN_WALK, GAIN_JUMP, GAIN_STOMP, GAIN_MUSIC, default 128 each, 8-bit unsigned Q1.7 channel gains (128 = unity).
REQ-004 SHALL have parameter LPF_SHIFT, default 2, one-pole filter coefficient as a right shift (1..8).
REQ-005 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-006 SHALL have port I_RSTn, input, 1, reset that is asynchronous and active-low.
REQ-007 SHALL have port audio_clk_en, input, 1, one-cycle sample strobe, one per CLOCK_RATE/SAMPLE_RATE cycles.
REQ-008 SHALL have ports walk_in, jump_in, stomp_in, music_in, input, signed 16 each, channel samples (walk_in from dk_walk out).
REQ-009 SHALL have port out, output, signed 16, mixed sample.
REQ-010 SHALL have port O_SOUND_DAT, output, 16, offset-binary mixed sample (out with MSB inverted).
REQ-011 SHALL have port out_valid, output, 1, one-cycle pulse when out/O_SOUND_DAT update.
REQ-012 SHALL have port overrun, output, 1, sticky flag for a strobe arriving while busy.

Function
REQ-013 SHALL implement FSM states IDLE, ACC, SAT, FILT, DONE; reset state IDLE.
REQ-014 On audio_clk_en in IDLE (cycle 0), SHALL snapshot all four inputs, clear the accumulator, enter ACC.
REQ-015 ACC SHALL last exactly 4 cycles (1-4), adding one channel per cycle in order walk, jump, stomp, music, each as signed input times its unsigned gain (24-bit signed product).
REQ-016 Accumulator SHALL be 26-bit signed; overflow within it is impossible by construction.
REQ-017 SAT (cycle 5) SHALL arithmetic-shift-right the sum by 7 (floor) and clamp to [-32768, 32767].
REQ-018 FILT (cycle 6) SHALL apply the filter stage per Configuration.
REQ-019 DONE (cycle 7) SHALL register out and O_SOUND_DAT, pulse out_valid for exactly one cycle, return to IDLE; total latency strobe-to-out_valid = 7 cycles.
REQ-020 out and O_SOUND_DAT SHALL hold their values between out_valid pulses.
REQ-021 audio_clk_en in any state other than IDLE SHALL be ignored and SHALL set overrun to 1 until reset.
REQ-022 Input changes after the cycle-0 snapshot SHALL NOT affect the sample in progress.
REQ-023 Compilation SHALL fail (elaboration assertion) if CLOCK_RATE/SAMPLE_RATE < 8.

Reset
REQ-024 I_RSTn low SHALL immediately force FSM to IDLE, accumulator and filter state to 0, out = 0, O_SOUND_DAT = 16'h8000, out_valid = 0, overrun = 0.
REQ-025 Reset asserted mid-operation SHALL abandon the sample in progress; no out_valid until a new strobe after release.
REQ-026 First strobe after reset release SHALL be processed normally.

Configuration
REQ-027 Macro DK_MIX_LPF_EN defined: FILT SHALL compute y = y + ((x - y) >>> LPF_SHIFT) with 17-bit signed difference, y 16-bit signed state, out = y.
REQ-028 Macro DK_MIX_LPF_EN undefined: FILT SHALL pass the saturated sum unchanged (out = x), no filter state, latency unchanged at 7 cycles.

Verification
REQ-029 No LPF, walk_in=1000, others 0, unity gains, strobe -> out_valid at cycle 7, out=1000, O_SOUND_DAT=33768.
REQ-030 No LPF, all inputs 32767, unity gains -> out=32767; all inputs -32768 -> out=-32768, O_SOUND_DAT=0.
REQ-031 No LPF, GAIN_WALK=64, walk_in=-1000, others 0 -> out=-500.
REQ-032 DK_MIX_LPF_EN, LPF_SHIFT=2, music_in step 0->16384 held -> out 4096, 7168, 9472 on successive out_valid.
REQ-033 Strobes at cycles 0 and 3 -> one out_valid at cycle 7, overrun=1 and remains 1 until I_RSTn low.
REQ-034 I_RSTn low during ACC -> out=0, O_SOUND_DAT=16'h8000, no out_valid; next strobe after release yields correct sample.
